// File: rtl/square_pkg.sv
// Shared types and constants for the square drawer: coordinate width, screen defaults, FSM states.
// Imported by the interface, the raster counter and the top level.
package square_pkg;
  localparam int COORD_W      = 11;
  localparam int CNT_W        = 6;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} draw_state_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/square_drawer_if.sv
// Game-control side (master) to square drawer (slave): start request, new location, pixel write port, status.
// No backpressure: the framebuffer accepts one pixel write per cycle.
interface square_drawer_if;
  import square_pkg::*;

  logic   start;
  coord_t x_loc;
  coord_t y_loc;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   pixel_color;
  logic   pixel_we;
  logic   busy;
  logic   done;

  modport master (
    output start, x_loc, y_loc,
    input  pixel_x, pixel_y, pixel_color, pixel_we, busy, done
  );

  modport slave (
    input  start, x_loc, y_loc,
    output pixel_x, pixel_y, pixel_color, pixel_we, busy, done
  );
endinterface

// File: rtl/square_raster_counter.sv
// Raster counter over a SIZE x SIZE square: cx inner, cy outer, one step per advance; zero latency last flag.
// Wraps to (0,0) after the last pixel so the erase and draw phases chain without an explicit clear.
module square_raster_counter
  import square_pkg::*;
#(
  parameter int SIZE = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output cnt_t cx,
  output cnt_t cy,
  output logic last
);
  localparam cnt_t MAX = cnt_t'(SIZE - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (cx == MAX) begin
        cx <= '0;
        cy <= (cy == MAX) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == MAX) && (cy == MAX);
endmodule

// File: rtl/square_drawer.sv
// Erases the previous square (black) then draws the new one (white), one pixel per cycle, fixed latency.
// No backpressure; off-screen pixels are clipped. Define SQUARE_OUTLINE_EN to write only the border.
module square_drawer
  import square_pkg::*;
#(
  parameter int SIZE     = 20,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic            clk,
  input  logic            reset,
  square_drawer_if.slave  bus
);
  localparam cnt_t MAX = cnt_t'(SIZE - 1);

  draw_state_t state;
  draw_state_t next_state;

  coord_t new_x;
  coord_t new_y;
  coord_t old_x;
  coord_t old_y;
  logic   old_valid;

  cnt_t cx;
  cnt_t cy;
  logic last;
  logic active;
  logic border;

  coord_t base_x;
  coord_t base_y;
  coord_t pix_x;
  coord_t pix_y;
  logic   color;
  logic   busy_c;
  logic   done_c;

  square_raster_counter #(.SIZE(SIZE)) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (!active),
    .advance (active),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = old_valid ? ERASE : DRAW;
      ERASE:   if (last)      next_state = DRAW;
      DRAW:    if (last)      next_state = DONE;
      DONE:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Location registers: new position captured on start, promoted to "old" once the draw completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_x     <= '0;
      new_y     <= '0;
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        new_x <= bus.x_loc;
        new_y <= bus.y_loc;
      end
      if (state == DRAW && last) begin
        old_x     <= new_x;
        old_y     <= new_y;
        old_valid <= 1'b1;
      end
    end
  end

  assign active = (state == ERASE) || (state == DRAW);

`ifdef SQUARE_OUTLINE_EN
  assign border = (cx == '0) || (cx == MAX) || (cy == '0) || (cy == MAX);
`else
  assign border = 1'b1;
`endif

  always_comb begin
    base_x = '0;
    base_y = '0;
    color  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      ERASE: begin
        base_x = old_x;
        base_y = old_y;
        busy_c = 1'b1;
      end
      DRAW: begin
        base_x = new_x;
        base_y = new_y;
        color  = 1'b1;
        busy_c = 1'b1;
      end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
    pix_x = active ? base_x + coord_t'(cx) : '0;
    pix_y = active ? base_y + coord_t'(cy) : '0;
  end

  assign bus.pixel_x     = pix_x;
  assign bus.pixel_y     = pix_y;
  assign bus.pixel_color = color;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  // Counters keep running over clipped pixels so the phase length never depends on position.
  assign bus.pixel_we    = active && border &&
                           (pix_x < coord_t'(SCREEN_W)) && (pix_y < coord_t'(SCREEN_H));
endmodule

// File: tb/tb_square_drawer.sv
// Bench for square_drawer: scoreboard of expected pixel writes built from a raster model, plus timing checks.
// Honours SQUARE_OUTLINE_EN the same way as the design.
module tb_square_drawer;
  import square_pkg::*;

  localparam int S = 20;
`ifdef SQUARE_OUTLINE_EN
  localparam int FULL = 76;
  localparam int CLIP = 19;
`else
  localparam int FULL = 400;
  localparam int CLIP = 100;
`endif

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        c;
  } pix_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  square_drawer_if bus();

  square_drawer #(.SIZE(S), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     wr_cnt  = 0;
  pix_t   exp_q[$];
  logic   m_old_valid = 1'b0;
  coord_t m_ox = '0;
  coord_t m_oy = '0;

  // Every framebuffer write must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    pix_t e;
    pix_t got;
    if (bus.pixel_we === 1'b1) begin
      wr_cnt++;
      n_tests++;
      got = '{bus.pixel_x, bus.pixel_y, bus.pixel_color};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got (%0d,%0d) color %0b, required no write",
                 got.x, got.y, got.c);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL write_pixel: got (%0d,%0d) color %0b, required (%0d,%0d) color %0b",
                   got.x, got.y, got.c, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic push_square(input coord_t x, input coord_t y, input logic c);
    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < S; i++) begin
        int   px;
        int   py;
        logic vis;
        px  = int'(x) + i;
        py  = int'(y) + j;
        vis = (px < 640) && (py < 480);
`ifdef SQUARE_OUTLINE_EN
        vis = vis && (i == 0 || i == S - 1 || j == 0 || j == S - 1);
`endif
        if (vis) exp_q.push_back('{11'(px), 11'(py), c});
      end
    end
  endtask

  // Call right after a negedge; the posedge it waits for is cycle 0 of the operation.
  task automatic start_op(input coord_t x, input coord_t y);
    if (m_old_valid) push_square(m_ox, m_oy, 1'b0);
    push_square(x, y, 1'b1);
    m_old_valid = 1'b1;
    m_ox        = x;
    m_oy        = y;
    wr_cnt      = 0;
    bus.x_loc   = x;
    bus.y_loc   = y;
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input int inj, output int done_cyc,
                           output int busy_cnt, output int first_we, output logic done_next);
    done_cyc  = 0;
    busy_cnt  = 0;
    first_we  = 0;
    done_next = 1'b0;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk);
      if (bus.start) bus.start = 1'b0;
      if (cyc == inj) begin
        bus.x_loc = 11'd300;
        bus.y_loc = 11'd300;
        bus.start = 1'b1;
      end
      if (bus.pixel_we === 1'b1 && first_we == 0) first_we = cyc;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        @(negedge clk);
        done_next = bus.done;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_old_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.x_loc = '0;
    bus.y_loc = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    n_tests += 6;
    if (bus.pixel_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we: got %b, required 0", bus.pixel_we); end
    if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    if (bus.pixel_x !== 11'd0)    begin n_fail++; $display("FAIL reset_px: got %0d, required 0", bus.pixel_x); end
    if (bus.pixel_y !== 11'd0)    begin n_fail++; $display("FAIL reset_py: got %0d, required 0", bus.pixel_y); end
    if (bus.pixel_color !== 1'b0) begin n_fail++; $display("FAIL reset_color: got %b, required 0", bus.pixel_color); end
    reset = 1'b0;
    m_old_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_first_draw();
    int dc, bc, fw;
    logic dn;
    start_op(11'd50, 11'd50);
    wait_done(1000, 0, dc, bc, fw, dn);
    n_tests += 6;
    if (dc != 401)         begin n_fail++; $display("FAIL first_done_cycle: got %0d, required 401", dc); end
    if (bc != 400)         begin n_fail++; $display("FAIL first_busy_cycles: got %0d, required 400", bc); end
    if (fw != 1)           begin n_fail++; $display("FAIL first_we_cycle: got %0d, required 1", fw); end
    if (dn !== 1'b0)       begin n_fail++; $display("FAIL first_done_pulse: got %b after done, required 0", dn); end
    if (wr_cnt != FULL)    begin n_fail++; $display("FAIL first_writes: got %0d, required %0d", wr_cnt, FULL); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL first_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_erase_redraw();
    int dc, bc, fw;
    logic dn;
    start_op(11'd345, 11'd343);
    wait_done(2000, 0, dc, bc, fw, dn);
    n_tests += 5;
    if (dc != 801)           begin n_fail++; $display("FAIL redraw_done_cycle: got %0d, required 801", dc); end
    if (bc != 800)           begin n_fail++; $display("FAIL redraw_busy_cycles: got %0d, required 800", bc); end
    if (fw != 1)             begin n_fail++; $display("FAIL redraw_we_cycle: got %0d, required 1", fw); end
    if (wr_cnt != 2 * FULL)  begin n_fail++; $display("FAIL redraw_writes: got %0d, required %0d", wr_cnt, 2 * FULL); end
    if (exp_q.size() != 0)   begin n_fail++; $display("FAIL redraw_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_clip();
    int dc, bc, fw;
    logic dn;
    do_reset();
    start_op(11'd630, 11'd470);
    wait_done(1000, 0, dc, bc, fw, dn);
    n_tests += 4;
    if (dc != 401)         begin n_fail++; $display("FAIL clip_done_cycle: got %0d, required 401", dc); end
    if (bc != 400)         begin n_fail++; $display("FAIL clip_busy_cycles: got %0d, required 400", bc); end
    if (wr_cnt != CLIP)    begin n_fail++; $display("FAIL clip_writes: got %0d, required %0d", wr_cnt, CLIP); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    int dc, bc, fw;
    logic dn;
    do_reset();
    start_op(11'd100, 11'd100);
    wait_done(1000, 150, dc, bc, fw, dn);
    n_tests += 3;
    if (dc != 401)         begin n_fail++; $display("FAIL ignore_done_cycle: got %0d, required 401", dc); end
    if (wr_cnt != FULL)    begin n_fail++; $display("FAIL ignore_writes: got %0d, required %0d", wr_cnt, FULL); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ignore_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, fw;
    logic dn;
    start_op(11'd0, 11'd0);
    wait_done(2000, 0, dc, bc, fw, dn);
    n_tests += 3;
    if (dc != 801)          begin n_fail++; $display("FAIL b2b_done_cycle: got %0d, required 801", dc); end
    if (wr_cnt != 2 * FULL) begin n_fail++; $display("FAIL b2b_writes: got %0d, required %0d", wr_cnt, 2 * FULL); end
    if (exp_q.size() != 0)  begin n_fail++; $display("FAIL b2b_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int dc, bc, fw;
    logic dn;
    start_op(11'd200, 11'd100);
    wait_done(600, 0, dc, bc, fw, dn);
    reset = 1'b1;
    @(negedge clk);
    n_tests += 4;
    if (dc != 0)               begin n_fail++; $display("FAIL mid_early_done: got done at %0d, required none", dc); end
    if (bus.pixel_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b, required 0", bus.pixel_we); end
    if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b, required 0", bus.busy); end
    if (bus.done !== 1'b0)     begin n_fail++; $display("FAIL mid_done: got %b, required 0", bus.done); end
    reset = 1'b0;
    exp_q.delete();
    m_old_valid = 1'b0;
    start_op(11'd10, 11'd20);
    wait_done(2000, 0, dc, bc, fw, dn);
    n_tests += 3;
    if (dc != 401)         begin n_fail++; $display("FAIL mid_redo_done_cycle: got %0d, required 401", dc); end
    if (wr_cnt != FULL)    begin n_fail++; $display("FAIL mid_redo_writes: got %0d, required %0d", wr_cnt, FULL); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_redo_missing: %0d writes outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_erase_redraw();
    test_clip();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
